// File: rtl/imem_loader.sv
// imem_loader: byte-serial loader writing 19-bit words into instruction memory from address 0
// Ports:
//   clk, rst (async active-low)       clock and reset
//   start                             begin a load (honoured only in IDLE)
//   rx_data, rx_valid / rx_ready      incoming byte stream: 2-byte length header, then 3 bytes per word
//   mem_we, mem_addr, mem_wdata       instruction memory write port
//   cpu_hold, busy                    high while a load is in progress
//   done, err                         completion pulse, sticky error flag
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [11:0] count;
  logic acc;
  assign acc = rx_valid && rx_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LEN_LO : IDLE;
      LEN_LO:  state_n = acc ? LEN_HI : LEN_LO;
      LEN_HI:  state_n = !acc ? LEN_HI : (|rx_data[7:4]) ? IDLE : ({rx_data[3:0], count[7:0]} == 12'd0) ? DONE : B0;
      B0:      state_n = acc ? B1 : B0;
      B1:      state_n = acc ? B2 : B1;
      B2:      state_n = acc ? WRITE : B2;
      WRITE:   state_n = (count == 12'd1) ? DONE : B0;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are flops decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_n;
      rx_ready <= state_n inside {LEN_LO, LEN_HI, B0, B1, B2};
      mem_we   <= state_n == WRITE;
      cpu_hold <= state_n != IDLE;
      busy     <= state_n != IDLE;
      done     <= state_n == DONE;
      if (state == IDLE && start) begin
        err      <= 1'b0;
        mem_addr <= '0;
      end
      if (acc && state == LEN_LO) count[7:0] <= rx_data;
      if (acc && state == LEN_HI) begin
        count[11:8] <= rx_data[3:0];
        if (|rx_data[7:4]) err <= 1'b1;
      end
      if (acc && state == B0) mem_wdata[7:0] <= rx_data;
      if (acc && state == B1) mem_wdata[15:8] <= rx_data;
      if (acc && state == B2) begin
        mem_wdata[DATA_W-1:16] <= rx_data[DATA_W-17:0];
        // Stray high bits flag an error but the word is still written.
        if (|rx_data[7:DATA_W-16]) err <= 1'b1;
      end
      if (state == WRITE) begin
        count    <= count - 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, scoreboard-checked bench for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [18:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               nb;
    logic [63:0]      bytes;
    int               gap;
    int               nw;
    logic [1:0][18:0] wd;
    bit               exp_err;
    bit               exp_done;
    bit               spam;
  } vec_t;

  vec_t        vecs[7];
  logic [30:0] sb[$];
  int          checks = 0;
  int          fails = 0;
  int          n_writes = 0;
  int          done_cnt = 0;
  int          exp_w = 0;
  bit          prev_we = 0;
  bit          prev_done = 0;
  bit          stop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      n_writes++;
      chk("write_hold", cpu_hold, 1);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else chk("write", {mem_addr, mem_wdata}, sb.pop_front());
    end
    if (done) begin
      done_cnt++;
      chk("done_after_we", prev_we, exp_w > 0);
      chk("done_hold", cpu_hold, 1);
    end
    if (prev_done) chk("hold_after_done", {cpu_hold, busy}, 0);
    prev_we = mem_we;
    prev_done = done;
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("byte_timeout", 1, 0);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int d0, w0, n;
    d0 = done_cnt;
    w0 = n_writes;
    exp_w = v.nw;
    for (int k = 0; k < v.nw; k++) sb.push_back({12'(k), v.wd[k]});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_hold_rise"}, {busy, cpu_hold}, 2'b11);
    if (v.spam) begin
      stop = 0;
      fork
        begin
          for (int i = 0; i < v.nb; i++) send(v.bytes[63-8*i -: 8], v.gap);
          stop = 1;
        end
        begin
          while (!stop) begin
            @(negedge clk);
            start = !start;
          end
          start = 1'b0;
        end
      join
    end else begin
      for (int i = 0; i < v.nb; i++) send(v.bytes[63-8*i -: 8], v.gap);
      if (v.nw == 0 && v.exp_done) chk({v.name, "_done_after_hdr"}, done, 1);
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_idle"}, busy, 0);
    chk({v.name, "_done_cnt"}, done_cnt - d0, v.exp_done);
    chk({v.name, "_writes"}, n_writes - w0, v.nw);
    chk({v.name, "_err"}, err, v.exp_err);
    chk({v.name, "_hold_end"}, cpu_hold, 0);
    chk({v.name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    vecs[0] = '{"basic",     8, 64'h0200341205FFFF07, 0, 2, {19'h7FFFF, 19'h51234}, 0, 1, 0};
    vecs[1] = '{"stall",     8, 64'h0200341205FFFF07, 5, 2, {19'h7FFFF, 19'h51234}, 0, 1, 0};
    vecs[2] = '{"zero",      2, 64'h0000000000000000, 0, 0, {19'h0, 19'h0},         0, 1, 0};
    vecs[3] = '{"hdr_err",   2, 64'h0110000000000000, 0, 0, {19'h0, 19'h0},         1, 0, 0};
    vecs[4] = '{"b2_err",    5, 64'h010034120D000000, 0, 1, {19'h0, 19'h51234},     1, 1, 0};
    vecs[5] = '{"err_clear", 5, 64'h0100AA5502000000, 0, 1, {19'h0, 19'h255AA},     0, 1, 0};
    vecs[6] = '{"spam",      8, 64'h0200341205FFFF07, 0, 2, {19'h7FFFF, 19'h51234}, 0, 1, 1};
    repeat (3) @(negedge clk);
    chk("reset_state", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}, 0);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    exp_w = 3;
    sb.push_back({12'd0, 19'h51234});
    sb.push_back({12'd1, 19'h7FFFF});
    n = n_writes + 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h05, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'h07, 0);
    for (int k = 0; k < 50 && n_writes < n; k++) @(negedge clk);
    chk("mid_writes", n_writes, n);
    #2 rst = 1'b0;
    #1 chk("mid_reset_async", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}, 0);
    chk("mid_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
